keyboard_poly_ctrl: RTL and testbench



---
 rtl/keyboard_poly_ctrl_if.sv | 31 +++
 rtl/keyboard_poly_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_keyboard_poly_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keyboard_poly_ctrl_if.sv
// rtl/keyboard_poly_ctrl_if.sv - key/octave/mode inputs and note outputs of the free-mode key front end
interface keyboard_poly_ctrl_if #(
    parameter int NUM_KEYS = 7,
    parameter int OCT_W    = 2,
    parameter int NOTE_W   = 5
);
    logic [NUM_KEYS-1:0] key;
    logic [OCT_W-1:0]    octave;
    logic [2:0]          mode;
    logic [NOTE_W-1:0]   note;
    logic                note_valid;
    logic                note_start;

    modport master (
        output key,
        output octave,
        output mode,
        input  note,
        input  note_valid,
        input  note_start
    );

    modport slave (
        input  key,
        input  octave,
        input  mode,
        output note,
        output note_valid,
        output note_start
    );
endinterface

// File: rtl/keyboard_poly_ctrl.sv
// rtl/keyboard_poly_ctrl.sv - debounced last-pressed-priority key to note mapper
// Optional release sustain tail is built when KEYBOARD_SUSTAIN_EN is defined.
module keyboard_poly_ctrl #(
    parameter int         NUM_KEYS        = 7,
    parameter int         NUM_OCTAVES     = 3,
    parameter int         OCT_W           = 2,
    parameter int         NOTE_W          = 5,
    parameter int         DEBOUNCE_CYCLES = 2000000,
    parameter int         SUSTAIN_CYCLES  = 10000000,
    parameter logic [2:0] MODE_FREE       = 3'b001
) (
    input logic                 clk,
    input logic                 rst_n,
    keyboard_poly_ctrl_if.slave kb
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    generate
        if (NUM_KEYS * NUM_OCTAVES > (2 ** NOTE_W) - 1) begin : g_note_w_check
            $error("NOTE_W cannot hold NUM_KEYS*NUM_OCTAVES");
        end
        if (DEBOUNCE_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_cycles_check
            $error("DEBOUNCE_CYCLES and SUSTAIN_CYCLES must be at least 1");
        end
    endgenerate

`ifdef KEYBOARD_SUSTAIN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, RELEASE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1} state_t;
`endif

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] deb_q;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];

    // Synchroniser plus per-key debounce counter; deb_q gives edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= kb.key;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        lowest = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    state_t              state;
    state_t              state_d;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    sel_d;
    logic [IDX_W-1:0]    cand;
    logic [NOTE_W-1:0]   note_r;
    logic [NOTE_W-1:0]   note_d;
    logic [NOTE_W-1:0]   cand_note;
    logic                start_r;
    logic                start_d;
    logic                latch;
    logic                mode_ok;
    logic                oct_ok;
    logic                sus_done;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;

    assign rise    = deb & ~deb_q;
    assign fall    = ~deb & deb_q;
    assign mode_ok = (kb.mode == MODE_FREE);
    assign oct_ok  = (int'(kb.octave) < NUM_OCTAVES);

    // A fresh press wins over re-selection after the selected key drops out.
    always_comb begin
        latch     = 1'b0;
        cand      = sel;
        if (rise != '0) begin
            latch = 1'b1;
            cand  = lowest(rise);
        end else if (state == PLAY && fall[sel] && deb != '0) begin
            latch = 1'b1;
            cand  = lowest(deb);
        end
        cand_note = NOTE_W'(int'(kb.octave) * NUM_KEYS + int'(cand) + 1);
    end

`ifdef KEYBOARD_SUSTAIN_EN
    localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
    logic [SUS_W-1:0] sus_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sus_cnt <= '0;
        end else if (state == RELEASE && state_d == RELEASE) begin
            sus_cnt <= sus_cnt + 1'b1;
        end else begin
            sus_cnt <= '0;
        end
    end

    assign sus_done = (sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1));
`else
    assign sus_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            note_r  <= '0;
            start_r <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            note_r  <= note_d;
            start_r <= start_d;
        end
    end

    always_comb begin
        state_d = state;
        if (!mode_ok) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (latch) state_d = oct_ok ? PLAY : IDLE;
                end
                PLAY: begin
                    if (latch) begin
                        state_d = oct_ok ? PLAY : IDLE;
                    end else if (deb == '0) begin
`ifdef KEYBOARD_SUSTAIN_EN
                        state_d = RELEASE;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef KEYBOARD_SUSTAIN_EN
                RELEASE: begin
                    if (latch) begin
                        state_d = oct_ok ? PLAY : IDLE;
                    end else if (sus_done) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Any non-IDLE next state reached with latch set implies mode and octave were valid.
    always_comb begin
        note_d  = note_r;
        sel_d   = sel;
        start_d = 1'b0;
        if (state_d == IDLE) begin
            note_d = '0;
        end else if (latch) begin
            note_d  = cand_note;
            sel_d   = cand;
            start_d = 1'b1;
        end
    end

    assign kb.note       = note_r;
    assign kb.note_valid = (note_r != '0);
    assign kb.note_start = start_r;
endmodule

// File: tb/tb_keyboard_poly_ctrl.sv
// tb/tb_keyboard_poly_ctrl.sv - directed bench with per-cycle behavioural model of keyboard_poly_ctrl
module tb_keyboard_poly_ctrl;
    localparam int D = 4;
    localparam int S = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    keyboard_poly_ctrl_if #(.NUM_KEYS(7), .OCT_W(2), .NOTE_W(5)) bus ();

    keyboard_poly_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SUSTAIN_CYCLES (S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kb   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [6:0] v);
        for (int i = 0; i < 7; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Model: a key's debounced level flips once its synchronised raw samples
    // have disagreed with it for D consecutive cycles.
    logic [6:0] hist [0:D];
    logic [6:0] m_deb;
    logic [6:0] m_deb_prev;
    int         m_phase;
    int         m_sel;
    int         m_left;
    int         m_note;
    int         m_start;

    always @(posedge clk or negedge rst_n) begin
        logic [6:0] rise;
        logic [6:0] fall;
        int         idx;
        bit         pick;
        bit         differ;
        if (!rst_n) begin
            for (int k = 0; k <= D; k++) hist[k] = '0;
            m_deb      = '0;
            m_deb_prev = '0;
            m_phase    = 0;
            m_sel      = 0;
            m_left     = 0;
            m_note     = 0;
            m_start    = 0;
        end else begin
            rise    = m_deb & ~m_deb_prev;
            fall    = ~m_deb & m_deb_prev;
            m_start = 0;
            pick    = 0;
            idx     = 0;
            if (bus.mode != 3'b001) begin
                m_phase = 0;
                m_note  = 0;
            end else begin
                if (rise != 0) begin
                    pick = 1;
                    idx  = lowest_set(rise);
                end else if (m_phase == 1 && fall[m_sel] && m_deb != 0) begin
                    pick = 1;
                    idx  = lowest_set(m_deb);
                end
                if (pick) begin
                    if (bus.octave < 3) begin
                        m_phase = 1;
                        m_sel   = idx;
                        m_note  = int'(bus.octave) * 7 + idx + 1;
                        m_start = 1;
                    end else begin
                        m_phase = 0;
                        m_note  = 0;
                    end
                end else if (m_phase == 1 && m_deb == 0) begin
`ifdef KEYBOARD_SUSTAIN_EN
                    m_phase = 2;
                    m_left  = S;
`else
                    m_phase = 0;
                    m_note  = 0;
`endif
                end else if (m_phase == 2) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0;
                        m_note  = 0;
                    end
                end
            end
            m_deb_prev = m_deb;
            for (int i = 0; i < 7; i++) begin
                differ = 1;
                for (int k = 1; k <= D; k++) begin
                    if (hist[k][i] == m_deb[i]) differ = 0;
                end
                if (differ) m_deb[i] = ~m_deb[i];
            end
            for (int k = D; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = bus.key;
        end
    end

    always @(negedge clk) begin
        chk("cyc_note", int'(bus.note), m_note);
        chk("cyc_valid", int'(bus.note_valid), (m_note != 0) ? 1 : 0);
        chk("cyc_start", int'(bus.note_start), m_start);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet();
        bus.key = '0;
        tick(2 * D + S + 10);
    endtask

    initial begin
        bus.key    = '0;
        bus.octave = 2'd0;
        bus.mode   = 3'b001;
        tick(2);
        chk("reset_note", int'(bus.note), 0);
        chk("reset_valid", int'(bus.note_valid), 0);
        rst_n = 1'b1;
        tick(3);

        // key[2], octave 1 -> 10 after D+3 edges
        bus.octave = 2'd1;
        bus.key    = 7'b0000100;
        tick(D + 2);
        chk("lat_before", int'(bus.note), 0);
        tick(1);
        chk("lat_note10", int'(bus.note), 10);
        chk("model_note10", m_note, 10);
        chk("lat_start", int'(bus.note_start), 1);
        tick(1);
        chk("start_one_cycle", int'(bus.note_start), 0);
        bus.key[4] = 1'b1;
        tick(D - 1);
        bus.key[4] = 1'b0;
        tick(12);
        chk("glitch_ignored", int'(bus.note), 10);
        quiet();
        chk("release_zero", int'(bus.note), 0);

        // last-pressed priority and fallback
        bus.key = 7'b0000001;
        tick(D + 3);
        chk("hold_k0", int'(bus.note), 8);
        bus.key[5] = 1'b1;
        tick(D + 3);
        chk("newest_k5", int'(bus.note), 13);
        chk("newest_start", int'(bus.note_start), 1);
        bus.key[5] = 1'b0;
        tick(D + 3);
        chk("fallback_k0", int'(bus.note), 8);
        chk("fallback_start", int'(bus.note_start), 1);
        bus.key[0] = 1'b0;
        tick(D + 2);
        chk("last_rel_before", int'(bus.note), 8);
        tick(1);
`ifdef KEYBOARD_SUSTAIN_EN
        chk("sustain_hold", int'(bus.note), 8);
        tick(S - 1);
        chk("sustain_end_before", int'(bus.note), 8);
        tick(1);
        chk("sustain_end", int'(bus.note), 0);
`else
        chk("last_rel_zero", int'(bus.note), 0);
        chk("model_rel_zero", m_note, 0);
`endif
        quiet();

        // simultaneous rise: lowest index wins
        bus.octave = 2'd2;
        bus.key    = 7'b0001010;
        tick(D + 3);
        chk("simul_16", int'(bus.note), 16);
        chk("model_16", m_note, 16);
        quiet();

        // mode gating
        bus.octave = 2'd1;
        bus.key    = 7'b0010000;
        tick(D + 3);
        chk("mode_pre12", int'(bus.note), 12);
        bus.mode = 3'b011;
        tick(1);
        chk("mode_off_note", int'(bus.note), 0);
        chk("mode_off_valid", int'(bus.note_valid), 0);
        tick(3);
        bus.mode = 3'b001;
        tick(10);
        chk("mode_reentry_held", int'(bus.note), 0);
        quiet();

        // invalid octave, then octave change during PLAY
        bus.octave = 2'd3;
        bus.key    = 7'b0000001;
        tick(D + 3);
        chk("oct3_note", int'(bus.note), 0);
        chk("oct3_start", int'(bus.note_start), 0);
        quiet();
        bus.octave = 2'd0;
        bus.key    = 7'b0001000;
        tick(D + 3);
        chk("oct0_k3", int'(bus.note), 4);
        bus.octave = 2'd2;
        tick(4);
        chk("oct_change_ignored", int'(bus.note), 4);
        bus.key[6] = 1'b1;
        tick(D + 3);
        chk("oct2_k6", int'(bus.note), 21);
        quiet();

        // async reset mid-note
        bus.octave = 2'd0;
        bus.key    = 7'b0000100;
        tick(D + 3);
        chk("pre_reset", int'(bus.note), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_note", int'(bus.note), 0);
        chk("async_rst_valid", int'(bus.note_valid), 0);
        bus.key = '0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("post_reset_quiet", int'(bus.note), 0);
        bus.key = 7'b0000010;
        tick(D + 3);
        chk("post_reset_press", int'(bus.note), 2);
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
